pattern_seq: RTL and testbench

Parametrised single-channel waveform sequencer. It generalises the hard-coded 3-state millisecond pulse FSM into a programmable segment table. Each segment holds a level for N ticks, and a tick is TICK_COUNT clocks. It plays a frame of up to NUM_SEG segments once or in a loop, and sits between the control regs and an output pin or LED driver.

---
 rtl/pattern_seq.sv | 185 ++++++++++++++++++
 tb/tb_pattern_seq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_seq.sv
// pattern_seq: programmable segment-table waveform sequencer (IDLE/RUN), one frame or looped.
// Define PATTERN_SEQ_REPEAT_EN to add rep_cnt/frame_idx for rep_cnt+1 back-to-back frames.
module pattern_seq #(
    parameter int unsigned TICK_COUNT = 27000,
    parameter int unsigned NUM_SEG    = 16,
    parameter int unsigned DUR_W      = 8,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_SEG)-1:0]   wr_addr,
    input  logic                         wr_level,
    input  logic [DUR_W-1:0]             wr_dur,
    input  logic [$clog2(NUM_SEG):0]     seg_count,
    input  logic                         loop,
    input  logic                         start,
    input  logic                         stop,
    output logic                         sig,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(NUM_SEG)-1:0]   seg_idx
`ifdef PATTERN_SEQ_REPEAT_EN
    ,
    input  logic [7:0]                   rep_cnt,
    output logic [7:0]                   frame_idx
`endif
);

    localparam int unsigned AW = $clog2(NUM_SEG);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = $clog2(TICK_COUNT);
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_COUNT - 1);
    localparam logic [AW-1:0] IDX_MAX  = AW'(NUM_SEG - 1);

    typedef struct packed {
        logic             level;
        logic [DUR_W-1:0] dur;
    } seg_t;

    typedef enum logic {IDLE, RUN} state_t;

    seg_t             table_q [NUM_SEG];
    state_t           state_q, state_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [DUR_W-1:0] tick_q, tick_d;
    logic [DUR_W-1:0] cur_dur_q, cur_dur_d;
    logic             sig_d, busy_d, done_d;
    logic [AW-1:0]    idx_d;
    logic             load;
    logic [AW-1:0]    load_idx;
    logic             cnt_ok, last_seg, seg_end;
    logic [DUR_W-1:0] last_tick;
`ifdef PATTERN_SEQ_REPEAT_EN
    logic [7:0]       rep_left_q, rep_left_d;
    logic [7:0]       frame_idx_d;
`endif

    // Segment table; no reset, written in any state.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_q[wr_addr] <= seg_t'{level: wr_level, dur: wr_dur};
        end
    end

    assign cnt_ok    = (seg_count != CW'(0)) && (seg_count <= CW'(NUM_SEG));
    assign last_tick = (cur_dur_q == DUR_W'(0)) ? DUR_W'(0) : cur_dur_q - DUR_W'(1);
    assign seg_end   = (pre_q == PRE_MAX) && (tick_q == last_tick);
    // seg_count is live: a shrink below the current index ends the frame at this segment.
    assign last_seg  = ((CW'(seg_idx) + CW'(1)) >= seg_count) || (seg_idx == IDX_MAX);

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        tick_d    = tick_q;
        cur_dur_d = cur_dur_q;
        sig_d     = sig;
        busy_d    = busy;
        done_d    = 1'b0;
        idx_d     = seg_idx;
        load      = 1'b0;
        load_idx  = '0;
`ifdef PATTERN_SEQ_REPEAT_EN
        rep_left_d  = rep_left_q;
        frame_idx_d = frame_idx;
`endif
        case (state_q)
            IDLE: begin
                sig_d  = IDLE_LEVEL;
                busy_d = 1'b0;
                pre_d  = '0;
                tick_d = '0;
                if (start && !stop && cnt_ok) begin
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    load     = 1'b1;
                    load_idx = '0;
`ifdef PATTERN_SEQ_REPEAT_EN
                    rep_left_d  = rep_cnt;
                    frame_idx_d = 8'd0;
`endif
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    sig_d   = IDLE_LEVEL;
                    busy_d  = 1'b0;
                    pre_d   = '0;
                    tick_d  = '0;
                end else if (seg_end) begin
                    pre_d  = '0;
                    tick_d = '0;
                    if (!last_seg) begin
                        load     = 1'b1;
                        load_idx = seg_idx + AW'(1);
                    end else if (loop) begin
                        load     = 1'b1;
                        load_idx = '0;
`ifdef PATTERN_SEQ_REPEAT_EN
                        frame_idx_d = frame_idx + 8'd1;
`endif
                    end
`ifdef PATTERN_SEQ_REPEAT_EN
                    else if (rep_left_q != 8'd0) begin
                        load        = 1'b1;
                        load_idx    = '0;
                        rep_left_d  = rep_left_q - 8'd1;
                        frame_idx_d = frame_idx + 8'd1;
                    end
`endif
                    else begin
                        state_d = IDLE;
                        sig_d   = IDLE_LEVEL;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else if (pre_q == PRE_MAX) begin
                    pre_d  = '0;
                    tick_d = tick_q + DUR_W'(1);
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Table is only read on segment entry, so mid-segment writes affect the next play.
        if (load) begin
            idx_d     = load_idx;
            sig_d     = table_q[load_idx].level;
            cur_dur_d = table_q[load_idx].dur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            tick_q    <= '0;
            cur_dur_q <= '0;
            sig       <= IDLE_LEVEL;
            busy      <= 1'b0;
            done      <= 1'b0;
            seg_idx   <= '0;
`ifdef PATTERN_SEQ_REPEAT_EN
            rep_left_q <= 8'd0;
            frame_idx  <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            tick_q    <= tick_d;
            cur_dur_q <= cur_dur_d;
            sig       <= sig_d;
            busy      <= busy_d;
            done      <= done_d;
            seg_idx   <= idx_d;
`ifdef PATTERN_SEQ_REPEAT_EN
            rep_left_q <= rep_left_d;
            frame_idx  <= frame_idx_d;
`endif
        end
    end

endmodule

// File: tb/tb_pattern_seq.sv
// tb_pattern_seq: directed scenarios plus random stimulus against a clock-countdown model.
module tb_pattern_seq;

    localparam int unsigned TICK = 4;
    localparam int unsigned NSEG = 16;
    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = $clog2(NSEG);
    localparam int unsigned CW   = AW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic          wr_level = 1'b0;
    logic [DW-1:0] wr_dur = '0;
    logic [CW-1:0] seg_count = '0;
    logic          loop = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          sig, busy, done;
    logic [AW-1:0] seg_idx;
`ifdef PATTERN_SEQ_REPEAT_EN
    logic [7:0]    rep_cnt = 8'd0;
    logic [7:0]    frame_idx;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pattern_seq #(
        .TICK_COUNT(TICK),
        .NUM_SEG   (NSEG),
        .DUR_W     (DW),
        .IDLE_LEVEL(1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_level (wr_level),
        .wr_dur   (wr_dur),
        .seg_count(seg_count),
        .loop     (loop),
        .start    (start),
        .stop     (stop),
        .sig      (sig),
        .busy     (busy),
        .done     (done),
        .seg_idx  (seg_idx)
`ifdef PATTERN_SEQ_REPEAT_EN
        ,
        .rep_cnt  (rep_cnt),
        .frame_idx(frame_idx)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    // Reference model: each segment is a countdown of max(dur,1)*TICK clocks.
    bit m_lvl [NSEG];
    int m_dur [NSEG];
    bit m_run = 1'b0, m_sig = 1'b0, m_done = 1'b0;
    int m_idx = 0, m_left = 0, m_frame = 0, m_reps = 0;

    task automatic m_enter(input int n);
        m_idx  = n;
        m_sig  = m_lvl[n];
        m_left = ((m_dur[n] == 0) ? 1 : m_dur[n]) * int'(TICK);
    endtask

    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_run = 1'b0; m_sig = 1'b0; m_idx = 0; m_frame = 0; m_reps = 0;
        end else if (!m_run) begin
            m_sig = 1'b0;
            if (start && !stop && int'(seg_count) >= 1 && int'(seg_count) <= int'(NSEG)) begin
                m_run = 1'b1;
                m_frame = 0;
`ifdef PATTERN_SEQ_REPEAT_EN
                m_reps = int'(rep_cnt);
`else
                m_reps = 0;
`endif
                m_enter(0);
            end
        end else if (stop) begin
            m_run = 1'b0; m_sig = 1'b0;
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (m_idx + 1 < int'(seg_count)) m_enter(m_idx + 1);
                else if (loop) begin m_frame = (m_frame + 1) % 256; m_enter(0); end
                else if (m_reps > 0) begin m_reps--; m_frame = (m_frame + 1) % 256; m_enter(0); end
                else begin m_run = 1'b0; m_sig = 1'b0; m_done = 1'b1; end
            end
        end
        if (wr_en) begin
            m_lvl[int'(wr_addr)] = wr_level;
            m_dur[int'(wr_addr)] = int'(wr_dur);
        end
    end

    always @(negedge clk) begin
        check("sig", 32'(sig), 32'(m_sig));
        check("busy", 32'(busy), 32'(m_run));
        check("done", 32'(done), 32'(m_done));
        if (m_run) check("seg_idx", 32'(seg_idx), 32'(m_idx));
`ifdef PATTERN_SEQ_REPEAT_EN
        check("frame_idx", 32'(frame_idx), 32'(m_frame));
`endif
    end

    task automatic wr(input int a, input bit l, input int d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_level = l; wr_dur = DW'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    function automatic bit basic_sig(input int c);
        return (c <= 8) ? 1'b1 : (c <= 12) ? 1'b0 : (c <= 24) ? 1'b1 : 1'b0;
    endfunction

    initial begin
        int dones;
        for (int i = 0; i < int'(NSEG); i++) begin m_lvl[i] = 1'b0; m_dur[i] = 0; end
        repeat (3) @(negedge clk);
        check("rst_sig", 32'(sig), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_seg_idx", 32'(seg_idx), 32'd0);
        rst = 1'b0;
        wr(0, 1'b1, 2); wr(1, 1'b0, 1); wr(2, 1'b1, 3);
        for (int i = 3; i < int'(NSEG); i++) wr(i, 1'($urandom), int'($urandom_range(0, 3)));

        // Basic frame
        seg_count = CW'(3); loop = 1'b0; start = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            check("basic_sig", 32'(sig), 32'(basic_sig(c)));
            if (c == 24) begin check("basic_busy24", 32'(busy), 32'd1); check("basic_done24", 32'(done), 32'd0); end
            if (c == 25) begin check("basic_busy25", 32'(busy), 32'd0); check("basic_done25", 32'(done), 32'd1); end
            if (c == 26) check("basic_done26", 32'(done), 32'd0);
        end

        // Loop, then release loop mid-frame
        loop = 1'b1; start = 1'b1; dones = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (done) dones++;
            if (c == 25) begin
                check("loop_sig25", 32'(sig), 32'd1);
                check("loop_idx25", 32'(seg_idx), 32'd0);
                check("loop_done25", 32'(done), 32'd0);
                loop = 1'b0;
            end
            if (c == 49) check("loop_done49", 32'(done), 32'd1);
        end
        check("loop_done_count", 32'(dones), 32'd1);

        // Zero duration and illegal seg_count
        wr(1, 1'b0, 0);
        start = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 9)  check("zero_idx9", 32'(seg_idx), 32'd1);
            if (c == 12) begin check("zero_sig12", 32'(sig), 32'd0); check("zero_idx12", 32'(seg_idx), 32'd1); end
            if (c == 13) begin check("zero_sig13", 32'(sig), 32'd1); check("zero_idx13", 32'(seg_idx), 32'd2); end
            if (c == 25) check("zero_done25", 32'(done), 32'd1);
        end
        seg_count = CW'(0); start = 1'b1;
        @(negedge clk);
        check("cnt0_busy", 32'(busy), 32'd0);
        seg_count = CW'(17);
        @(negedge clk);
        check("cnt17_busy", 32'(busy), 32'd0);
        start = 1'b0; seg_count = CW'(3);
        @(negedge clk);

        // Abort, then start blocked by stop
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 10) stop = 1'b1;
            if (c == 11) begin
                check("abort_sig", 32'(sig), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                start = 1'b1;
            end
            if (c == 12) check("startstop_busy", 32'(busy), 32'd0);
        end
        start = 1'b0; stop = 1'b0;
        @(negedge clk);

        // Reset mid-frame
        start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 6) rst = 1'b1;
            if (c == 7) begin
                check("midrst_sig", 32'(sig), 32'd0);
                check("midrst_busy", 32'(busy), 32'd0);
                check("midrst_idx", 32'(seg_idx), 32'd0);
                rst = 1'b0;
            end
        end

        // Write to the playing segment only shows on its next play
        loop = 1'b1; start = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 3) begin wr_en = 1'b1; wr_addr = AW'(0); wr_level = 1'b0; wr_dur = DW'(2); end
            if (c == 4) wr_en = 1'b0;
            if (c == 8) check("wrrun_sig8", 32'(sig), 32'd1);
            if (c == 25) begin
                check("wrrun_sig25", 32'(sig), 32'd0);
                check("wrrun_idx25", 32'(seg_idx), 32'd0);
                stop = 1'b1;
            end
            if (c == 26) begin check("wrrun_busy26", 32'(busy), 32'd0); stop = 1'b0; end
        end
        loop = 1'b0;
        wr(0, 1'b1, 2);

        // Back-to-back with start held
        start = 1'b1;
        for (int c = 1; c <= 27; c++) begin
            @(negedge clk);
            if (c == 25) begin check("b2b_done25", 32'(done), 32'd1); check("b2b_busy25", 32'(busy), 32'd0); end
            if (c == 26) begin
                check("b2b_busy26", 32'(busy), 32'd1);
                check("b2b_sig26", 32'(sig), 32'd1);
                check("b2b_done26", 32'(done), 32'd0);
                start = 1'b0; stop = 1'b1;
            end
            if (c == 27) begin check("b2b_busy27", 32'(busy), 32'd0); stop = 1'b0; end
        end

`ifdef PATTERN_SEQ_REPEAT_EN
        // Three back-to-back frames, one done
        rep_cnt = 8'd2; start = 1'b1; dones = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 1) begin start = 1'b0; check("rep_fi1", 32'(frame_idx), 32'd0); end
            if (done) dones++;
            if (c == 25) begin check("rep_fi25", 32'(frame_idx), 32'd1); check("rep_busy25", 32'(busy), 32'd1); end
            if (c == 49) check("rep_fi49", 32'(frame_idx), 32'd2);
            if (c == 73) begin check("rep_done73", 32'(done), 32'd1); check("rep_fi73", 32'(frame_idx), 32'd2); end
        end
        check("rep_done_count", 32'(dones), 32'd1);
        rep_cnt = 8'd0;
`endif

        // Random stimulus against the model
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            wr_en    = ($urandom_range(0, 7) == 0);
            wr_addr  = AW'($urandom);
            wr_level = 1'($urandom);
            wr_dur   = DW'($urandom_range(0, 3));
            start    = ($urandom_range(0, 9) == 0);
            stop     = ($urandom_range(0, 59) == 0);
            rst      = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 49) == 0) loop = ~loop;
            if ($urandom_range(0, 39) == 0) seg_count = CW'($urandom_range(0, NSEG));
`ifdef PATTERN_SEQ_REPEAT_EN
            rep_cnt = 8'($urandom_range(0, 2));
`endif
        end
        wr_en = 1'b0; start = 1'b0; rst = 1'b0; stop = 1'b1;
        repeat (2) @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
